// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Bundles the fetch stage's instruction-memory port, its decode
//             handshake and the execute-stage redirect into one interface.
//             The "master" modport is the fetch stage's view. The "slave"
//             modport is the surrounding pipeline and memory.
//  Signals  : imem_req/imem_addr/imem_rdata  - synchronous imem, 1-cycle read
//             inst_valid/inst_ready/inst_out/inst_pc - prefetch FIFO head
//             redirect_valid/redirect_pc      - branch/jump restart
//             fetch_err                       - misaligned-redirect pulse
//             fifo_count                      - prefetch occupancy
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic [31:0]        imem_rdata;
    logic               inst_valid;
    logic               inst_ready;
    logic [31:0]        inst_out;
    logic [XLEN-1:0]    inst_pc;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               fetch_err;
    logic [c_cnt_w-1:0] fifo_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        output inst_valid, inst_out, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fetch_err, fifo_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        input  inst_valid, inst_out, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fetch_err, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Decoupled instruction-fetch front end. The unit owns the PC and
//             issues sequential word fetches to a 1-cycle-latency memory. It
//             buffers {pc, instr} pairs in a prefetch FIFO for decode. A
//             redirect from execute flushes the FIFO and restarts fetch.
//  Ports    : clk  - clock, all state on the rising edge
//             rst  - synchronous active-high reset
//             bus  - fetch_unit_if.master (imem, decode, redirect, status)
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fetch_unit_if.master    bus
);
    localparam int c_aw    = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    // One extra bit so that count + inflight - pop never wraps.
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]    r_fetch_pc;
    logic               r_inflight_v;
    logic [XLEN-1:0]    r_inflight_pc;
    logic               r_squash;
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_fetch_err;

    logic [XLEN-1:0]    r_mem_pc    [FIFO_DEPTH];
    logic [31:0]        r_mem_instr [FIFO_DEPTH];

    logic               w_inst_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [c_cnt_w:0]   w_occ;

    // Head is hidden during a redirect so decode can never consume a stale
    // instruction in the flush cycle.
    assign w_inst_valid = (r_count != '0) & ~bus.redirect_valid;
    assign w_pop        = w_inst_valid & bus.inst_ready;

    // Slots committed after this edge: buffered + returning - leaving.
    // Counting the pop as a credit lets the request issue in the same cycle
    // decode frees an entry, which keeps a steady one-per-cycle stream.
    assign w_occ   = {1'b0, r_count} + (c_cnt_w + 1)'(r_inflight_v)
                   - (c_cnt_w + 1)'(w_pop);
    assign w_issue = ~rst & ~bus.redirect_valid & (w_occ < c_depth);

    assign w_push  = r_inflight_v & ~r_squash & ~bus.redirect_valid;

    assign bus.imem_req   = w_issue;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.inst_valid = w_inst_valid;
    assign bus.inst_out   = r_mem_instr[r_rd_ptr];
    assign bus.inst_pc    = r_mem_pc[r_rd_ptr];
    assign bus.fetch_err  = r_fetch_err;
    assign bus.fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_squash      <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_fetch_err <= bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
            if (bus.redirect_valid) begin
                r_fetch_pc   <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                r_inflight_v <= 1'b0;
                r_squash     <= 1'b1;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_count      <= '0;
            end else begin
                r_inflight_v <= w_issue;
                if (w_issue) begin
                    r_fetch_pc    <= r_fetch_pc + XLEN'(4);
                    r_inflight_pc <= r_fetch_pc;
                    r_squash      <= 1'b0;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage is not reset; only entries behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
            r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit (XLEN=32,
//             RESET_PC=0, FIFO_DEPTH=4). The memory model returns the
//             request address XOR a fixed key one cycle after each request.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    localparam logic [31:0] c_key = 32'hDEAD_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   issued;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32), .FIFO_DEPTH(4)) bus ();

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= bus.imem_addr ^ c_key;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the reset edge, in cycle 0.
    task automatic do_reset;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_rdata     = '0;

        // ---------------- reset release and streaming ----------------
        cyc(); cyc(); #1;
        check("rst_req",   32'(bus.imem_req),   0);
        check("rst_count", 32'(bus.fifo_count), 0);
        check("rst_valid", 32'(bus.inst_valid), 0);
        check("rst_err",   32'(bus.fetch_err),  0);
        check("rst_addr",  bus.imem_addr,       32'h0);
        rst = 1'b0; #1;
        check("c0_req",  32'(bus.imem_req), 1);
        check("c0_addr", bus.imem_addr,     32'h0);
        cyc(); #1;
        check("c1_addr",  bus.imem_addr,       32'h4);
        check("c1_valid", 32'(bus.inst_valid), 0);
        cyc(); #1;
        check("c2_valid", 32'(bus.inst_valid), 1);
        check("c2_pc",    bus.inst_pc,         32'h0);
        check("c2_out",   bus.inst_out,        32'h0 ^ c_key);
        check("c2_addr",  bus.imem_addr,       32'h8);
        for (int k = 1; k <= 2; k++) begin
            cyc(); #1;
            check("stream_pc",    bus.inst_pc,         32'(4 * k));
            check("stream_count", 32'(bus.fifo_count), 1);
        end

        // ---------------- backpressure ----------------
        do_reset();
        bus.inst_ready = 1'b0;
        issued = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.imem_req) begin
                check("bp_addr", bus.imem_addr, 32'(4 * issued));
                issued++;
            end
            cyc();
        end
        #1;
        check("bp_issued", 32'(issued),          4);
        check("bp_count",  32'(bus.fifo_count),  4);
        check("bp_req",    32'(bus.imem_req),    0);
        check("bp_head",   bus.inst_pc,          32'h0);
        bus.inst_ready = 1'b1; #1;
        check("bp_credit_req", 32'(bus.imem_req), 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_rel_valid", 32'(bus.inst_valid), 1);
            check("bp_rel_pc",    bus.inst_pc,         32'(4 * k));
            check("bp_rel_out",   bus.inst_out,        32'(4 * k) ^ c_key);
            cyc(); #1;
        end

        // ---------------- redirect with full pipeline ----------------
        do_reset();
        bus.inst_ready = 1'b0;
        cyc(); cyc(); cyc(); cyc(); #1;
        check("rd_pre_count", 32'(bus.fifo_count), 3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        bus.inst_ready     = 1'b1; #1;
        check("rd_r_valid", 32'(bus.inst_valid), 0);
        check("rd_r_req",   32'(bus.imem_req),   0);
        cyc(); bus.redirect_valid = 1'b0; #1;
        check("rd_r1_count", 32'(bus.fifo_count), 0);
        check("rd_r1_valid", 32'(bus.inst_valid), 0);
        check("rd_r1_req",   32'(bus.imem_req),   1);
        check("rd_r1_addr",  bus.imem_addr,       32'h100);
        check("rd_r1_err",   32'(bus.fetch_err),  0);
        cyc(); #1;
        check("rd_r2_valid", 32'(bus.inst_valid), 0);
        cyc(); #1;
        check("rd_r3_valid", 32'(bus.inst_valid), 1);
        check("rd_r3_pc",    bus.inst_pc,         32'h100);
        check("rd_r3_out",   bus.inst_out,        32'h100 ^ c_key);
        cyc(); #1;
        check("rd_r4_pc", bus.inst_pc, 32'h104);

        // ---------------- misaligned redirect ----------------
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102; #1;
        check("mis_r_err", 32'(bus.fetch_err), 0);
        cyc(); bus.redirect_valid = 1'b0; #1;
        check("mis_r1_err",  32'(bus.fetch_err), 1);
        check("mis_r1_addr", bus.imem_addr,      32'h100);
        cyc(); #1;
        check("mis_r2_err", 32'(bus.fetch_err), 0);
        cyc(); #1;
        check("mis_r3_pc", bus.inst_pc, 32'h100);

        // ---------------- address wrap ----------------
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        cyc(); bus.redirect_valid = 1'b0; #1;
        check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        cyc(); #1;
        check("wrap_addr1", bus.imem_addr, 32'h0);
        cyc(); #1;
        check("wrap_pc0", bus.inst_pc, 32'hFFFF_FFFC);
        cyc(); #1;
        check("wrap_pc1", bus.inst_pc, 32'h0);

        // ---------------- back-to-back redirects ----------------
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h301;
        cyc();
        bus.redirect_pc    = 32'h400; #1;
        check("b2b_err1", 32'(bus.fetch_err), 1);
        check("b2b_req1", 32'(bus.imem_req),  0);
        cyc(); bus.redirect_valid = 1'b0; #1;
        check("b2b_err2", 32'(bus.fetch_err), 0);
        check("b2b_addr", bus.imem_addr,      32'h400);
        check("b2b_req2", 32'(bus.imem_req),  1);
        cyc(); cyc(); #1;
        check("b2b_valid", 32'(bus.inst_valid), 1);
        check("b2b_pc",    bus.inst_pc,         32'h400);

        // ---------------- reset mid-stream ----------------
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        bus.inst_ready     = 1'b0;
        cyc(); bus.redirect_valid = 1'b0;
        cyc(); cyc(); cyc(); #1;
        check("mr_pre_count", 32'(bus.fifo_count), 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.inst_ready = 1'b1; #1;
        check("mr_count", 32'(bus.fifo_count), 0);
        check("mr_valid", 32'(bus.inst_valid), 0);
        check("mr_addr",  bus.imem_addr,       32'h0);
        check("mr_req",   32'(bus.imem_req),   1);
        cyc(); #1;
        check("mr_c1_count", 32'(bus.fifo_count), 0);
        cyc(); #1;
        check("mr_c2_valid", 32'(bus.inst_valid), 1);
        check("mr_c2_pc",    bus.inst_pc,         32'h0);
        check("mr_c2_out",   bus.inst_out,        32'h0 ^ c_key);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the next-generation RISC-V core. It replaces the single-cycle "PC register + PC+4 + next-PC mux" arrangement with a decoupled stage. The stage owns the program counter and issues sequential requests to a synchronous instruction memory with one cycle of read latency. It buffers returned instructions with their PCs in a prefetch FIFO and accepts branch/jump redirects from execute, squashing stale fetches.

## Interface

Parameters:
- XLEN, 32: PC/address width.
- RESET_PC, 0: first fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4: prefetch entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock; single clock domain, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  fetch address (word aligned).
- imem_rdata  in  32  instruction returned exactly one cycle after the request.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_out  out  32  head instruction.
- inst_pc  out  XLEN  PC of the head instruction.
- redirect_valid  in  1  taken branch/jump; flush and restart.
- redirect_pc  in  XLEN  restart target.
- fetch_err  out  1  one-cycle pulse: redirect target had nonzero bits [1:0].
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

## Operation

- State:
  - fetch_pc (XLEN).
  - One in-flight slot: inflight_v, inflight_pc, squash bit.
  - FIFO of {pc, instr} with rd/wr pointers and a count.
- pop = inst_valid & inst_ready & ~redirect_valid.
- Issue rule: imem_req = ~rst & ~redirect_valid & (count + inflight_v − pop < FIFO_DEPTH). This sustains one instruction per cycle for any FIFO_DEPTH ≥ 2. The FIFO can never overflow.
- imem_addr = fetch_pc. On issue:
  - fetch_pc ← fetch_pc + 4, wrapping modulo 2^XLEN.
  - inflight_v ← 1, inflight_pc ← fetch_pc.
  - With no issue, inflight_v ← 0.
- Response: if inflight_v & ~squash, push {inflight_pc, imem_rdata} into the FIFO.
- Push and pop in the same cycle are both performed; count is unchanged.
- Redirect cycle (redirect_valid = 1):
  - FIFO emptied: pointers ← 0, count ← 0.
  - Any response arriving this cycle is discarded.
  - inflight_v ← 0.
  - fetch_pc ← {redirect_pc[XLEN−1:2], 2'b00}.
  - inst_valid forced 0, so no pop occurs.
  - imem_req = 0.
- Misaligned redirect: bits [1:0] are cleared and fetch proceeds from the aligned address. fetch_err pulses high the cycle after the redirect.
- Back-to-back redirects: the last one wins. Each redirect produces its own fetch_err evaluation.
- inst_valid = (count ≠ 0) & ~redirect_valid. inst_out and inst_pc present the head entry and are stable while inst_valid & ~inst_ready.
- Reset values:
  - fetch_pc = RESET_PC, imem_addr = RESET_PC.
  - imem_req = 0, inflight_v = 0, count = 0, inst_valid = 0, fetch_err = 0.
  - FIFO contents are don't-care.
- Reset mid-operation: all of the above are restored on the next edge. An in-flight response arriving the cycle after reset is dropped (inflight_v = 0).

## Timing

- First cycle with rst low = cycle 0:
  - cycle 0: imem_req = 1, imem_addr = RESET_PC.
  - cycle 1: response pushed at the end of the cycle.
  - cycle 2: inst_valid = 1 with inst_pc = RESET_PC.
- Fetch-to-decode latency is 2 cycles; there is no bypass from imem_rdata to inst_out.
- Redirect asserted in cycle r:
  - cycle r+1: request to the target.
  - cycle r+3: target instruction valid.
- Steady state with inst_ready held high: one instruction per cycle and consecutive PCs. fifo_count stays at 1.
- Backpressure with inst_ready low: requests stop once count + inflight reaches FIFO_DEPTH. Exactly FIFO_DEPTH entries are held. There are no lost or duplicated PCs.
- When inst_ready returns high, a request issues in that same cycle (pop credit).

## Test plan

- Reset release, inst_ready = 1, memory returns instr = address: imem_addr 0,4,8,… from cycle 0; inst_valid from cycle 2; inst_pc/inst_out 0x0,0x4,0x8 on consecutive cycles.
- inst_ready = 0 for 10 cycles, FIFO_DEPTH = 4: exactly 4 requests issue (0x0–0xC), fifo_count = 4, imem_req = 0 thereafter. Release ready: PCs 0x0,0x4,0x8,0xC,0x10 in order, no gaps.
- Redirect to 0x100 while FIFO holds 3 entries and a request is in flight: inst_valid = 0 at r and r+1/r+2, imem_addr = 0x100 at r+1, inst_pc = 0x100 at r+3. No stale PC is ever presented.
- Redirect to 0x102: fetch_err = 1 for exactly one cycle (r+1); fetch resumes at 0x100.
- fetch_pc at 0xFFFF_FFFC (via redirect) with XLEN = 32: next request address wraps to 0x0000_0000.
- rst asserted for one cycle mid-stream with FIFO count 2: next cycle fifo_count = 0, inst_valid = 0, imem_addr = RESET_PC; the first post-reset instruction has inst_pc = RESET_PC.
